// File: rtl/pipe_control_unit.sv
// pipe_control_unit
// Pipelined RV32 control unit: decodes the ID-stage opcode, carries the
// control bundle through ID/EX, EX/MEM and MEM/WB, detects load-use / RAW
// hazards, squashes ID on a taken branch, produces the EX forwarding selects
// and counts stall cycles in a saturating counter.
//
// Handshake: id_valid qualifies the ID-stage instruction fields. stall is the
// inverse of a ready: while stall=1 the ID instruction is not consumed and
// the fetch side must hold PC and IF/ID unchanged; when stall=0 the
// instruction (or a bubble, if id_valid=0) is taken into ID/EX at the next
// rising edge.
module pipe_control_unit #(
    parameter int REG_AW = 5,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [6:0]        instr_opcode,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              branch_taken,
    output logic              stall,
    output logic              ex_mem_read_en,
    output logic              ex_mem_write_en,
    output logic              ex_reg_write_en,
    output logic              ex_branch_flag,
    output logic [1:0]        ex_alu_ctrl,
    output logic              ex_alu_src,
    output logic [REG_AW-1:0] ex_rd,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic              wb_reg_write_en,
    output logic [1:0]        wb_data_sel,
    output logic [REG_AW-1:0] wb_rd,
    output logic [1:0]        mux_a_sel,
    output logic [1:0]        mux_b_sel,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    localparam logic [1:0] SEL_RF    = 2'b00;
    localparam logic [1:0] SEL_MEMWB = 2'b01;
    localparam logic [1:0] SEL_EXMEM = 2'b10;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Control bundle; field order follows the decode table.
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_ctrl;
        logic       alu_src;
        logic [1:0] wb_sel;
    } ctrl_t;

    // ID-stage decode results
    ctrl_t             dec;
    logic              dec_known;
    logic              use_rs1;
    logic              use_rs2;

    // ID/EX register
    ctrl_t             idex_ctrl;
    logic              idex_use_rs1;
    logic              idex_use_rs2;
    logic [REG_AW-1:0] idex_rs1;
    logic [REG_AW-1:0] idex_rs2;
    logic [REG_AW-1:0] idex_rd;

    // EX/MEM register (only what later stages and forwarding need)
    logic              exmem_reg_write;
    logic              exmem_mem_read;
    logic              exmem_mem_write;
    logic [1:0]        exmem_wb_sel;
    logic [REG_AW-1:0] exmem_rd;

    // MEM/WB register
    logic              memwb_reg_write;
    logic [1:0]        memwb_wb_sel;
    logic [REG_AW-1:0] memwb_rd;

    logic              hazard;
    logic              load_use;
    logic              raw_idex;
    logic              raw_exmem;

    // A source matches a producer only if it is used and the producer really
    // writes a non-x0 register with that number.
    function automatic logic src_match(
        input logic              used,
        input logic [REG_AW-1:0] src,
        input logic              prod_wr,
        input logic [REG_AW-1:0] prod_rd
    );
        return used && prod_wr && (prod_rd != '0) && (prod_rd == src);
    endfunction

    // Opcode decode; unknown opcodes and invalid slots become a bubble.
    always_comb begin
        dec       = '0;
        dec_known = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        if (id_valid) begin
            case (instr_opcode)
                OP_R: begin
                    dec       = ctrl_t'(9'b1_0_0_0_10_0_00);
                    dec_known = 1'b1;
                    use_rs1   = 1'b1;
                    use_rs2   = 1'b1;
                end
                OP_I: begin
                    dec       = ctrl_t'(9'b1_0_0_0_11_1_00);
                    dec_known = 1'b1;
                    use_rs1   = 1'b1;
                end
                OP_LOAD: begin
                    dec       = ctrl_t'(9'b1_1_0_0_00_1_01);
                    dec_known = 1'b1;
                    use_rs1   = 1'b1;
                end
                OP_STORE: begin
                    dec       = ctrl_t'(9'b0_0_1_0_00_1_00);
                    dec_known = 1'b1;
                    use_rs1   = 1'b1;
                    use_rs2   = 1'b1;
                end
                OP_BR: begin
                    dec       = ctrl_t'(9'b0_0_0_1_01_0_00);
                    dec_known = 1'b1;
                    use_rs1   = 1'b1;
                    use_rs2   = 1'b1;
                end
                default: begin
                    dec       = '0;
                    dec_known = 1'b0;
                end
            endcase
        end
    end

    // Hazard detection against the instructions ahead of ID.
    always_comb begin
        raw_idex  = src_match(use_rs1, id_rs1, idex_ctrl.reg_write, idex_rd) ||
                    src_match(use_rs2, id_rs2, idex_ctrl.reg_write, idex_rd);
        raw_exmem = src_match(use_rs1, id_rs1, exmem_reg_write, exmem_rd) ||
                    src_match(use_rs2, id_rs2, exmem_reg_write, exmem_rd);
        load_use  = idex_ctrl.mem_read && raw_idex;
        if (FWD_EN != 0) begin
            hazard = load_use;
        end else begin
            // MEM/WB is not checked: the register file writes before it reads.
            hazard = raw_idex || raw_exmem;
        end
        // A taken branch flushes ID anyway, so holding it would be pointless.
        stall = hazard && !branch_taken;
    end

    // ID/EX register: flush has priority over stall, both insert a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_ctrl    <= '0;
            idex_use_rs1 <= 1'b0;
            idex_use_rs2 <= 1'b0;
            idex_rs1     <= '0;
            idex_rs2     <= '0;
            idex_rd      <= '0;
        end else if (branch_taken || stall) begin
            idex_ctrl    <= '0;
            idex_use_rs1 <= 1'b0;
            idex_use_rs2 <= 1'b0;
            idex_rs1     <= '0;
            idex_rs2     <= '0;
            idex_rd      <= '0;
        end else begin
            idex_ctrl    <= dec;
            idex_use_rs1 <= use_rs1;
            idex_use_rs2 <= use_rs2;
            idex_rs1     <= use_rs1 ? id_rs1 : '0;
            idex_rs2     <= use_rs2 ? id_rs2 : '0;
            idex_rd      <= dec_known ? id_rd : '0;
        end
    end

    // EX/MEM register: always advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exmem_reg_write <= 1'b0;
            exmem_mem_read  <= 1'b0;
            exmem_mem_write <= 1'b0;
            exmem_wb_sel    <= 2'b00;
            exmem_rd        <= '0;
        end else begin
            exmem_reg_write <= idex_ctrl.reg_write;
            exmem_mem_read  <= idex_ctrl.mem_read;
            exmem_mem_write <= idex_ctrl.mem_write;
            exmem_wb_sel    <= idex_ctrl.wb_sel;
            exmem_rd        <= idex_rd;
        end
    end

    // MEM/WB register: always advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memwb_reg_write <= 1'b0;
            memwb_wb_sel    <= 2'b00;
            memwb_rd        <= '0;
        end else begin
            memwb_reg_write <= exmem_reg_write;
            memwb_wb_sel    <= exmem_wb_sel;
            memwb_rd        <= exmem_rd;
        end
    end

    // EX operand forwarding; the younger EX/MEM result wins over MEM/WB.
    always_comb begin
        mux_a_sel = SEL_RF;
        mux_b_sel = SEL_RF;
        if (FWD_EN != 0) begin
            if (src_match(idex_use_rs1, idex_rs1, exmem_reg_write, exmem_rd)) begin
                mux_a_sel = SEL_EXMEM;
            end else if (src_match(idex_use_rs1, idex_rs1, memwb_reg_write, memwb_rd)) begin
                mux_a_sel = SEL_MEMWB;
            end
            if (src_match(idex_use_rs2, idex_rs2, exmem_reg_write, exmem_rd)) begin
                mux_b_sel = SEL_EXMEM;
            end else if (src_match(idex_use_rs2, idex_rs2, memwb_reg_write, memwb_rd)) begin
                mux_b_sel = SEL_MEMWB;
            end
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Output mapping of the pipeline registers.
    always_comb begin
        ex_mem_read_en  = idex_ctrl.mem_read;
        ex_mem_write_en = idex_ctrl.mem_write;
        ex_reg_write_en = idex_ctrl.reg_write;
        ex_branch_flag  = idex_ctrl.branch;
        ex_alu_ctrl     = idex_ctrl.alu_ctrl;
        ex_alu_src      = idex_ctrl.alu_src;
        ex_rd           = idex_rd;
        mem_read_en     = exmem_mem_read;
        mem_write_en    = exmem_mem_write;
        wb_reg_write_en = memwb_reg_write;
        wb_data_sel     = memwb_wb_sel;
        wb_rd           = memwb_rd;
    end

endmodule

// File: tb/tb_pipe_control_unit.sv
// tb_pipe_control_unit
// Three DUT instances share one stimulus: a = forwarding (default counter),
// b = stall-only, c = stall-only with a 2-bit counter.
module tb_pipe_control_unit;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_B = 7'b1100011;
    localparam logic [6:0] OP_X = 7'b1111111;

    int total = 0;
    int bad   = 0;

    // clock / reset / shared inputs
    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [6:0] instr_opcode;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       branch_taken;

    always #5 clk = ~clk;

    // instance a outputs
    logic a_stall, a_ex_mem_read_en, a_ex_mem_write_en, a_ex_reg_write_en, a_ex_branch_flag, a_ex_alu_src;
    logic a_mem_read_en, a_mem_write_en, a_wb_reg_write_en;
    logic [1:0] a_ex_alu_ctrl, a_wb_data_sel, a_mux_a_sel, a_mux_b_sel;
    logic [4:0] a_ex_rd, a_wb_rd;
    logic [15:0] a_stall_cnt;
    // instance b outputs
    logic b_stall, b_ex_mem_read_en, b_ex_mem_write_en, b_ex_reg_write_en, b_ex_branch_flag, b_ex_alu_src;
    logic b_mem_read_en, b_mem_write_en, b_wb_reg_write_en;
    logic [1:0] b_ex_alu_ctrl, b_wb_data_sel, b_mux_a_sel, b_mux_b_sel;
    logic [4:0] b_ex_rd, b_wb_rd;
    logic [15:0] b_stall_cnt;
    // instance c outputs
    logic c_stall, c_ex_mem_read_en, c_ex_mem_write_en, c_ex_reg_write_en, c_ex_branch_flag, c_ex_alu_src;
    logic c_mem_read_en, c_mem_write_en, c_wb_reg_write_en;
    logic [1:0] c_ex_alu_ctrl, c_wb_data_sel, c_mux_a_sel, c_mux_b_sel;
    logic [4:0] c_ex_rd, c_wb_rd;
    logic [1:0] c_stall_cnt;

    // grouped views: ex = {mem_read, mem_write, reg_write, branch, alu_ctrl, alu_src, rd}
    logic [11:0] a_ex, b_ex, c_ex;
    logic [1:0]  a_mem;
    logic [7:0]  a_wb;
    logic [42:0] a_all, b_all;
    logic [28:0] c_all;

    assign a_ex  = {a_ex_mem_read_en, a_ex_mem_write_en, a_ex_reg_write_en, a_ex_branch_flag, a_ex_alu_ctrl, a_ex_alu_src, a_ex_rd};
    assign b_ex  = {b_ex_mem_read_en, b_ex_mem_write_en, b_ex_reg_write_en, b_ex_branch_flag, b_ex_alu_ctrl, b_ex_alu_src, b_ex_rd};
    assign c_ex  = {c_ex_mem_read_en, c_ex_mem_write_en, c_ex_reg_write_en, c_ex_branch_flag, c_ex_alu_ctrl, c_ex_alu_src, c_ex_rd};
    assign a_mem = {a_mem_read_en, a_mem_write_en};
    assign a_wb  = {a_wb_reg_write_en, a_wb_data_sel, a_wb_rd};
    assign a_all = {a_stall, a_ex, a_mem, a_wb, a_mux_a_sel, a_mux_b_sel, a_stall_cnt};
    assign b_all = {b_stall, b_ex, b_mem_read_en, b_mem_write_en, b_wb_reg_write_en, b_wb_data_sel, b_wb_rd,
                    b_mux_a_sel, b_mux_b_sel, b_stall_cnt};
    assign c_all = {c_stall, c_ex, c_mem_read_en, c_mem_write_en, c_wb_reg_write_en, c_wb_data_sel, c_wb_rd,
                    c_mux_a_sel, c_mux_b_sel, c_stall_cnt};

    pipe_control_unit #(.REG_AW(5), .FWD_EN(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .instr_opcode(instr_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .branch_taken(branch_taken),
        .stall(a_stall), .ex_mem_read_en(a_ex_mem_read_en), .ex_mem_write_en(a_ex_mem_write_en),
        .ex_reg_write_en(a_ex_reg_write_en), .ex_branch_flag(a_ex_branch_flag), .ex_alu_ctrl(a_ex_alu_ctrl),
        .ex_alu_src(a_ex_alu_src), .ex_rd(a_ex_rd), .mem_read_en(a_mem_read_en), .mem_write_en(a_mem_write_en),
        .wb_reg_write_en(a_wb_reg_write_en), .wb_data_sel(a_wb_data_sel), .wb_rd(a_wb_rd),
        .mux_a_sel(a_mux_a_sel), .mux_b_sel(a_mux_b_sel), .stall_cnt(a_stall_cnt)
    );

    pipe_control_unit #(.REG_AW(5), .FWD_EN(0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .instr_opcode(instr_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .branch_taken(branch_taken),
        .stall(b_stall), .ex_mem_read_en(b_ex_mem_read_en), .ex_mem_write_en(b_ex_mem_write_en),
        .ex_reg_write_en(b_ex_reg_write_en), .ex_branch_flag(b_ex_branch_flag), .ex_alu_ctrl(b_ex_alu_ctrl),
        .ex_alu_src(b_ex_alu_src), .ex_rd(b_ex_rd), .mem_read_en(b_mem_read_en), .mem_write_en(b_mem_write_en),
        .wb_reg_write_en(b_wb_reg_write_en), .wb_data_sel(b_wb_data_sel), .wb_rd(b_wb_rd),
        .mux_a_sel(b_mux_a_sel), .mux_b_sel(b_mux_b_sel), .stall_cnt(b_stall_cnt)
    );

    pipe_control_unit #(.REG_AW(5), .FWD_EN(0), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .id_valid(id_valid), .instr_opcode(instr_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .branch_taken(branch_taken),
        .stall(c_stall), .ex_mem_read_en(c_ex_mem_read_en), .ex_mem_write_en(c_ex_mem_write_en),
        .ex_reg_write_en(c_ex_reg_write_en), .ex_branch_flag(c_ex_branch_flag), .ex_alu_ctrl(c_ex_alu_ctrl),
        .ex_alu_src(c_ex_alu_src), .ex_rd(c_ex_rd), .mem_read_en(c_mem_read_en), .mem_write_en(c_mem_write_en),
        .wb_reg_write_en(c_wb_reg_write_en), .wb_data_sel(c_wb_data_sel), .wb_rd(c_wb_rd),
        .mux_a_sel(c_mux_a_sel), .mux_b_sel(c_mux_b_sel), .stall_cnt(c_stall_cnt)
    );

    // scoreboard queues for the decode pipeline walk
    logic [11:0] ex_q[$];
    logic [1:0]  mem_q[$];
    logic [7:0]  wb_q[$];

    // expected ID/EX view from the decode table
    function automatic logic [11:0] exp_ex(input logic v, input logic [6:0] op, input logic [4:0] rd);
        if (!v) return 12'b0;
        case (op)
            OP_R:    return {1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, rd};
            OP_I:    return {1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1, rd};
            OP_L:    return {1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, rd};
            OP_S:    return {1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, rd};
            OP_B:    return {1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, rd};
            default: return 12'b0;
        endcase
    endfunction

    // expected EX/MEM strobes {mem_read, mem_write}
    function automatic logic [1:0] exp_mem(input logic v, input logic [6:0] op);
        if (!v) return 2'b00;
        case (op)
            OP_L:    return 2'b10;
            OP_S:    return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // expected MEM/WB view {reg_write, wb_sel, rd}
    function automatic logic [7:0] exp_wb(input logic v, input logic [6:0] op, input logic [4:0] rd);
        if (!v) return 8'b0;
        case (op)
            OP_R, OP_I: return {1'b1, 2'b00, rd};
            OP_L:       return {1'b1, 2'b01, rd};
            OP_S, OP_B: return {1'b0, 2'b00, rd};
            default:    return 8'b0;
        endcase
    endfunction

    // driver tasks
    task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd);
        id_valid     = v;
        instr_opcode = op;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_rd        = rd;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        branch_taken = 1'b0;
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        branch_taken = 1'b0;
        rst = 1'b1;
        drive(1'b1, OP_R, 5'd3, 5'd4, 5'd5);
        #2;
        total++; if (a_all !== '0) begin bad++; $display("FAIL reset_a: got %h want 0", a_all); end
        total++; if (b_all !== '0) begin bad++; $display("FAIL reset_b: got %h want 0", b_all); end
        total++; if (c_all !== '0) begin bad++; $display("FAIL reset_c: got %h want 0", c_all); end
        tick();
        rst = 1'b0;
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        tick();
        total++; if (a_all !== '0) begin bad++; $display("FAIL reset_idle_a: got %h want 0", a_all); end
    endtask

    task automatic test_decode;
        logic [6:0] ops[8];
        logic [11:0] e_ex;
        logic [1:0]  e_mem;
        logic [7:0]  e_wb;
        ops = '{OP_R, OP_L, OP_S, OP_B, OP_X, OP_I, 7'd0, 7'd0};
        do_reset();
        ex_q.delete(); mem_q.delete(); wb_q.delete();
        mem_q.push_back(2'b00);
        wb_q.push_back(8'b0);
        wb_q.push_back(8'b0);
        for (int i = 0; i < 8; i++) begin
            logic v;
            logic [4:0] rs1, rs2, rd;
            v   = (i < 6);
            rs1 = 5'($urandom_range(16, 31));
            rs2 = 5'($urandom_range(16, 31));
            rd  = (ops[i] == OP_S || ops[i] == OP_B) ? 5'd0 : 5'($urandom_range(1, 15));
            drive(v, ops[i], rs1, rs2, rd);
            ex_q.push_back(exp_ex(v, ops[i], rd));
            mem_q.push_back(exp_mem(v, ops[i]));
            wb_q.push_back(exp_wb(v, ops[i], rd));
            #1;
            total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL decode_stall step %0d: got %b want 0", i, a_stall); end
            tick();
            e_ex  = ex_q.pop_front();
            e_mem = mem_q.pop_front();
            e_wb  = wb_q.pop_front();
            total++; if (a_ex !== e_ex) begin bad++; $display("FAIL decode_ex step %0d: got %b want %b", i, a_ex, e_ex); end
            total++; if (a_mem !== e_mem) begin bad++; $display("FAIL decode_mem step %0d: got %b want %b", i, a_mem, e_mem); end
            total++; if (a_wb !== e_wb) begin bad++; $display("FAIL decode_wb step %0d: got %b want %b", i, a_wb, e_wb); end
        end
    endtask

    task automatic test_load_use;
        do_reset();
        drive(1'b1, OP_L, 5'd1, 5'd0, 5'd5);
        tick();
        drive(1'b1, OP_R, 5'd5, 5'd7, 5'd6);
        #1;
        total++; if (a_stall !== 1'b1) begin bad++; $display("FAIL lu_stall_on: got %b want 1", a_stall); end
        tick();
        total++; if (a_ex !== 12'b0) begin bad++; $display("FAIL lu_bubble: got %b want 0", a_ex); end
        total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL lu_stall_off: got %b want 0", a_stall); end
        tick();
        total++; if (a_ex !== exp_ex(1'b1, OP_R, 5'd6)) begin bad++; $display("FAIL lu_ex: got %b want %b", a_ex, exp_ex(1'b1, OP_R, 5'd6)); end
        total++; if (a_mux_a_sel !== 2'b01) begin bad++; $display("FAIL lu_mux_a: got %b want 01", a_mux_a_sel); end
        total++; if (a_mux_b_sel !== 2'b00) begin bad++; $display("FAIL lu_mux_b: got %b want 00", a_mux_b_sel); end
        total++; if (a_stall_cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt: got %0d want 1", a_stall_cnt); end
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic test_forward;
        do_reset();
        drive(1'b1, OP_R, 5'd1, 5'd2, 5'd3);
        tick();
        drive(1'b1, OP_R, 5'd3, 5'd3, 5'd4);
        #1;
        total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL fwd_nostall: got %b want 0", a_stall); end
        tick();
        total++; if (a_mux_a_sel !== 2'b10) begin bad++; $display("FAIL fwd_exmem_a: got %b want 10", a_mux_a_sel); end
        total++; if (a_mux_b_sel !== 2'b10) begin bad++; $display("FAIL fwd_exmem_b: got %b want 10", a_mux_b_sel); end
        // add x3, independent, then sub x4,x3,x3 -> MEM/WB forward
        drive(1'b1, OP_R, 5'd1, 5'd2, 5'd3);
        tick();
        drive(1'b1, OP_R, 5'd20, 5'd21, 5'd9);
        tick();
        drive(1'b1, OP_R, 5'd3, 5'd3, 5'd4);
        tick();
        total++; if (a_mux_a_sel !== 2'b01) begin bad++; $display("FAIL fwd_memwb_a: got %b want 01", a_mux_a_sel); end
        total++; if (a_mux_b_sel !== 2'b01) begin bad++; $display("FAIL fwd_memwb_b: got %b want 01", a_mux_b_sel); end
        // x4 written twice in a row: the younger (EX/MEM) wins
        drive(1'b1, OP_R, 5'd10, 5'd11, 5'd4);
        tick();
        drive(1'b1, OP_R, 5'd4, 5'd9, 5'd8);
        tick();
        total++; if (a_mux_a_sel !== 2'b10) begin bad++; $display("FAIL fwd_priority_a: got %b want 10", a_mux_a_sel); end
        total++; if (a_mux_b_sel !== 2'b00) begin bad++; $display("FAIL fwd_priority_b: got %b want 00", a_mux_b_sel); end
        // I-type: rs2 field is unused, rs1 = x0
        drive(1'b1, OP_I, 5'd0, 5'd8, 5'd7);
        tick();
        total++; if (a_mux_b_sel !== 2'b00) begin bad++; $display("FAIL fwd_unused_rs2: got %b want 00", a_mux_b_sel); end
        total++; if (a_mux_a_sel !== 2'b00) begin bad++; $display("FAIL fwd_x0_rs1: got %b want 00", a_mux_a_sel); end
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic test_nofwd;
        do_reset();
        drive(1'b1, OP_R, 5'd1, 5'd2, 5'd3);
        tick();
        drive(1'b1, OP_R, 5'd3, 5'd1, 5'd4);
        #1;
        total++; if (b_stall !== 1'b1) begin bad++; $display("FAIL nf_stall1: got %b want 1", b_stall); end
        tick();
        total++; if (b_stall !== 1'b1) begin bad++; $display("FAIL nf_stall2: got %b want 1", b_stall); end
        total++; if (b_ex !== 12'b0) begin bad++; $display("FAIL nf_bubble: got %b want 0", b_ex); end
        tick();
        total++; if (b_stall !== 1'b0) begin bad++; $display("FAIL nf_stall3: got %b want 0", b_stall); end
        total++; if (b_stall_cnt !== 16'd2) begin bad++; $display("FAIL nf_cnt: got %0d want 2", b_stall_cnt); end
        tick();
        total++; if (b_ex !== exp_ex(1'b1, OP_R, 5'd4)) begin bad++; $display("FAIL nf_ex: got %b want %b", b_ex, exp_ex(1'b1, OP_R, 5'd4)); end
        total++; if ({b_mux_a_sel, b_mux_b_sel} !== 4'b0000) begin bad++; $display("FAIL nf_mux: got %b want 0000", {b_mux_a_sel, b_mux_b_sel}); end
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic test_branch_flush;
        do_reset();
        drive(1'b1, OP_L, 5'd1, 5'd0, 5'd5);
        tick();
        drive(1'b1, OP_R, 5'd5, 5'd7, 5'd6);
        branch_taken = 1'b1;
        #1;
        total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL br_stall: got %b want 0", a_stall); end
        tick();
        branch_taken = 1'b0;
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        total++; if (a_ex !== 12'b0) begin bad++; $display("FAIL br_flush: got %b want 0", a_ex); end
        total++; if (a_mem_read_en !== 1'b1) begin bad++; $display("FAIL br_advance: got %b want 1", a_mem_read_en); end
        total++; if (a_stall_cnt !== 16'd0) begin bad++; $display("FAIL br_cnt: got %0d want 0", a_stall_cnt); end
    endtask

    task automatic test_x0;
        do_reset();
        drive(1'b1, OP_L, 5'd1, 5'd0, 5'd0);
        tick();
        drive(1'b1, OP_R, 5'd0, 5'd0, 5'd6);
        #1;
        total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL x0_stall_a: got %b want 0", a_stall); end
        total++; if (b_stall !== 1'b0) begin bad++; $display("FAIL x0_stall_b: got %b want 0", b_stall); end
        tick();
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        total++; if (a_ex_rd !== 5'd6) begin bad++; $display("FAIL x0_ex_rd: got %0d want 6", a_ex_rd); end
        total++; if (a_mux_a_sel !== 2'b00) begin bad++; $display("FAIL x0_mux_a: got %b want 00", a_mux_a_sel); end
        total++; if (a_stall_cnt !== 16'd0) begin bad++; $display("FAIL x0_cnt: got %0d want 0", a_stall_cnt); end
    endtask

    // Feed one dependent instruction into instance c and walk its 2-cycle stall.
    task automatic c_dep(input logic [4:0] rs1, input logic [4:0] rd, inout int cnt_exp);
        logic exp_st;
        drive(1'b1, OP_R, rs1, 5'd1, rd);
        for (int k = 0; k < 3; k++) begin
            exp_st = (k < 2);
            #1;
            total++; if (c_stall !== exp_st) begin bad++; $display("FAIL sat_stall rd%0d k%0d: got %b want %b", rd, k, c_stall, exp_st); end
            if (exp_st && cnt_exp < 3) cnt_exp++;
            tick();
            total++; if (c_stall_cnt !== 2'(cnt_exp)) begin bad++; $display("FAIL sat_cnt rd%0d k%0d: got %0d want %0d", rd, k, c_stall_cnt, cnt_exp); end
        end
    endtask

    task automatic test_saturate_rst;
        int cnt_exp;
        cnt_exp = 0;
        do_reset();
        drive(1'b1, OP_R, 5'd1, 5'd2, 5'd3);
        tick();
        c_dep(5'd3, 5'd4, cnt_exp);
        c_dep(5'd4, 5'd5, cnt_exp);
        // fifth stall cycle, then reset in the middle of the second one
        drive(1'b1, OP_R, 5'd5, 5'd1, 5'd6);
        #1;
        total++; if (c_stall !== 1'b1) begin bad++; $display("FAIL sat_stall5: got %b want 1", c_stall); end
        tick();
        total++; if (c_stall_cnt !== 2'd3) begin bad++; $display("FAIL sat_hold: got %0d want 3", c_stall_cnt); end
        total++; if (c_stall !== 1'b1) begin bad++; $display("FAIL sat_midstall: got %b want 1", c_stall); end
        rst = 1'b1;
        #1;
        total++; if (c_all !== '0) begin bad++; $display("FAIL async_rst_c: got %h want 0", c_all); end
        total++; if (a_all !== '0) begin bad++; $display("FAIL async_rst_a: got %h want 0", a_all); end
        #2;
        rst = 1'b0;
        tick();
        total++; if (c_ex !== exp_ex(1'b1, OP_R, 5'd6)) begin bad++; $display("FAIL post_rst_load: got %b want %b", c_ex, exp_ex(1'b1, OP_R, 5'd6)); end
        total++; if (c_stall_cnt !== 2'd0) begin bad++; $display("FAIL post_rst_cnt: got %0d want 0", c_stall_cnt); end
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        branch_taken = 1'b0;
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        test_reset();
        test_decode();
        test_load_use();
        test_forward();
        test_nofwd();
        test_branch_flush();
        test_x0();
        test_saturate_rst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
